vram_arbiter: RTL
=================

// Module: vram_arbiter
// PURPOSE
//   Shares one single-port synchronous pixel/colour RAM (64K x 15b RGB555) between three requesters:
//   - the VGA scan-out read, which is never stalled;
//   - a buffered write port for sprite/ball and Wii-driven updates;
//   - an auxiliary read port for the sprite engine.
//   Sits between vga_controller/bouncing_ball and the colour RAM in the 100 MHz pixel-clock domain.
// PARAMETERS
//   ADDR_W      16  RAM address width ({col[7:0],row[7:0]})
//   DATA_W      15  RAM word width (RGB555)
//   FIFO_DEPTH  4   write-buffer entries (power of 2, >=2)
// PORTS
//   clock         in   1       pixel clock (100 MHz); sole clock
//   reset_n       in   1       asynchronous, active-low reset
//   disp_req      in   1       display needs a pixel read this cycle (visible region)
//   disp_addr     in   ADDR_W  display read address
//   disp_valid    out  1       disp_data valid
//   disp_data     out  DATA_W  display pixel, fixed latency
//   wr_valid      in   1       write request
//   wr_ready      out  1       write buffer can accept
//   wr_addr       in   ADDR_W  write address
//   wr_data       in   DATA_W  write data
//   rd_valid      in   1       aux read request
//   rd_ready      out  1       aux read issued this cycle (handshake completes)
//   rd_addr       in   ADDR_W  aux read address
//   rd_data_valid out  1       rd_data valid
//   rd_data       out  DATA_W  aux read result
//   ram_addr      out  ADDR_W  RAM address (registered)
//   ram_we        out  1       RAM write enable (registered)
//   ram_wdata     out  DATA_W  RAM write data (registered)
//   ram_rdata     in   DATA_W  RAM read data, valid 1 cycle after ram_addr
//   wr_level      out  3       current write-buffer occupancy
// BEHAVIOUR
// - One RAM slot per cycle; grant decided combinationally in cycle N; ram_* registered, driven in N+1.
// - Priority: disp_req always wins. Remaining slots alternate between write-buffer head and aux read (round-robin):
//   - 1-bit last-grant pointer; after reset it favours write;
//   - it only toggles when both were pending and one was granted.
// - Display latency is fixed at 3 cycles (DISP_LATENCY): disp_req@N -> disp_valid=1, disp_data@N+3.
//   - No gaps, no misses; top level delays HS/VS/BLANK by 3.
// - Aux read: rd_ready=rd_valid & granted; rd_data_valid=1 exactly 3 cycles after the rd_ready cycle.
// - Write buffer: FIFO, push when wr_valid & wr_ready; wr_ready = !full (combinational).
//   - A push into a full FIFO is refused even if a pop occurs that cycle.
//   - Push+pop in the same cycle leaves wr_level unchanged.
//   - Writes commit in acceptance order; the popped head drives ram_we=1 the next cycle.
// - Hazard: if rd_addr equals the address of any valid FIFO entry, aux read is not granted (rd_ready=0).
//   - Writes take every free slot until the matching entry retires; aux then sees the new data.
// - Display read vs pending write to the same address: display returns the old RAM value (allowed).
// - Owner tag pipeline (2 stages, OWN_NONE/OWN_DISP/OWN_AUX) routes ram_rdata to disp_data or rd_data.
//   - The data register feeds exactly one valid strobe.
// - Idle cycle (no requests): ram_we=0, ram_addr holds its previous value.
// - Reset (async assert, sync deassert by top level):
//   - all outputs 0; wr_ready=0 while reset_n=0; FIFO empty; wr_level=0;
//   - tag pipe cleared, so in-flight reads never produce a valid strobe;
//   - wr_ready=1 on the first cycle after release.
// STRUCTURE
// - Package vram_pkg:
//   - ADDR_W and DATA_W defaults;
//   - DISP_LATENCY=3;
//   - owner_t enum {OWN_NONE, OWN_DISP, OWN_AUX}.
// - Sub-module vram_wr_fifo: FIFO_DEPTH-entry register FIFO with level output and per-entry address compare
//   (hit output) for the hazard check.
// - Arbiter, owner pipeline and output registers live in vram_arbiter.
// TESTING (RAM model preloaded with data = addr[14:0], 1-cycle read latency)
// 1. Assert reset_n=0 during a display burst -> all valids/ram_we 0, wr_ready 0; after release wr_ready=1, wr_level=0,
//    and no stale disp_valid.
// 2. disp_req=1 for 1280 cycles, addr 0..1279, wr_valid=1 -> disp_valid exactly 3 cycles later, data=addr, no gap;
//    4 writes accepted then wr_ready=0; ram_we=0 throughout the burst.
// 3. disp_req drops with 4 queued writes -> ram_we=1 on 4 consecutive cycles in acceptance order;
//    wr_ready=1 after the first pop.
// 4. No display; wr_valid and rd_valid held high -> grants W,R,W,R...; rd_data_valid 3 cycles after each rd_ready.
// 5. Write (0x1234, 0x7FFF) queued during display; aux read 0x1234 -> rd_ready=0 until the write commits;
//    rd_data=0x7FFF.
// 6. FIFO level 2, push+pop same cycle -> wr_level stays 2; full FIFO + pop + wr_valid -> push refused.

Source files
------------

// File: rtl/vram_pkg.sv
// vram_pkg: shared widths, display latency and read-owner tags for the VRAM arbiter
package vram_pkg;
    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 15;
    localparam int DISP_LATENCY = 3;
    typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_AUX} owner_t;
endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: register FIFO buffering RAM writes, with occupancy and address-hit lookup
module vram_wr_fifo #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 15,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full,
    output logic [LVL_W-1:0]  level,
    input  logic [ADDR_W-1:0] cmp_addr,
    output logic              hit
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic              push_ok, pop_ok;

    assign empty     = lvl_q == '0;
    assign full      = lvl_q == LVL_W'(DEPTH);
    assign level     = lvl_q;
    assign head_addr = addr_q[rp_q];
    assign head_data = data_q[rp_q];
    // full is registered, so a push into a full FIFO is refused even when a pop happens alongside
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;

    // pointer, valid-bit and storage updates for push/pop
    always_comb begin
        wp_d   = wp_q;
        rp_d   = rp_q;
        vld_d  = vld_q;
        addr_d = addr_q;
        data_d = data_q;
        if (pop_ok) begin
            rp_d        = rp_q + PW'(1);
            vld_d[rp_q] = 1'b0;
        end
        if (push_ok) begin
            wp_d         = wp_q + PW'(1);
            vld_d[wp_q]  = 1'b1;
            addr_d[wp_q] = push_addr;
            data_d[wp_q] = push_data;
        end
        lvl_d = lvl_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end

    // any live entry matching the compare address blocks a read of stale RAM data
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (vld_q[i] && addr_q[i] == cmp_addr) hit = 1'b1;
    end

    // FIFO state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp_q   <= '0;
            rp_q   <= '0;
            lvl_q  <= '0;
            vld_q  <= '0;
            addr_q <= '{default: '0};
            data_q <= '{default: '0};
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            lvl_q  <= lvl_d;
            vld_q  <= vld_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port colour RAM between display scan-out, buffered writes and aux reads
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [2:0]        wr_level
);
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int OWN_STAGES = DISP_LATENCY - 1;

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d, head_addr;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d, head_data;
    logic [DATA_W-1:0] disp_data_q, disp_data_d, rd_data_q, rd_data_d;
    logic              ram_we_q, ram_we_d, pref_wr_q, pref_wr_d;
    logic              disp_valid_q, disp_valid_d, rd_dv_q, rd_dv_d;
    logic              wr_pend, rd_pend, gnt_wr, gnt_rd, empty, full, hit;
    logic [LVL_W-1:0]  lvl;
    owner_t            own_q [OWN_STAGES];
    owner_t            own_d [OWN_STAGES];

    vram_wr_fifo #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (wr_valid),
        .push_addr(wr_addr),
        .push_data(wr_data),
        .pop      (gnt_wr),
        .head_addr(head_addr),
        .head_data(head_data),
        .empty    (empty),
        .full     (full),
        .level    (lvl),
        .cmp_addr (rd_addr),
        .hit      (hit)
    );

    assign wr_ready      = reset_n && !full;
    assign rd_ready      = reset_n && gnt_rd;
    assign wr_level      = 3'(lvl);
    assign ram_addr      = ram_addr_q;
    assign ram_we        = ram_we_q;
    assign ram_wdata     = ram_wdata_q;
    assign disp_valid    = disp_valid_q;
    assign disp_data     = disp_data_q;
    assign rd_data_valid = rd_dv_q;
    assign rd_data       = rd_data_q;

    // display always wins; leftover slots alternate write/aux, pointer moves only on contention
    always_comb begin
        wr_pend     = !empty;
        rd_pend     = rd_valid && !hit;
        gnt_wr      = !disp_req && wr_pend && (!rd_pend || pref_wr_q);
        gnt_rd      = !disp_req && rd_pend && (!wr_pend || !pref_wr_q);
        pref_wr_d   = (!disp_req && wr_pend && rd_pend) ? !pref_wr_q : pref_wr_q;
        ram_addr_d  = disp_req ? disp_addr : gnt_wr ? head_addr : gnt_rd ? rd_addr : ram_addr_q;
        ram_we_d    = gnt_wr;
        ram_wdata_d = gnt_wr ? head_data : ram_wdata_q;
    end

    // owner tags follow each read through the RAM and steer the returned word to one output
    always_comb begin
        own_d[0] = disp_req ? OWN_DISP : gnt_rd ? OWN_AUX : OWN_NONE;
        for (int i = 1; i < OWN_STAGES; i++) own_d[i] = own_q[i-1];
        disp_valid_d = own_q[OWN_STAGES-1] == OWN_DISP;
        rd_dv_d      = own_q[OWN_STAGES-1] == OWN_AUX;
        disp_data_d  = disp_valid_d ? ram_rdata : disp_data_q;
        rd_data_d    = rd_dv_d ? ram_rdata : rd_data_q;
    end

    // RAM command, owner pipeline and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= '0;
            pref_wr_q    <= 1'b1;
            own_q        <= '{default: OWN_NONE};
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            rd_dv_q      <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            pref_wr_q    <= pref_wr_d;
            own_q        <= own_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            rd_dv_q      <= rd_dv_d;
            rd_data_q    <= rd_data_d;
        end
    end
endmodule
